// File: rtl/mult_control_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encoding,
// datapath mux select levels and default sizing.
package mult_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SEL_LOAD     = 1'b1;
    localparam logic SEL_FEEDBACK = 1'b0;

    localparam int ITERATIONS_DEF = 32;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier controller: clear, increment, and a
// terminal flag on the last iteration, where it wraps back to zero.
module mult_iter_counter
    import mult_control_pkg::*;
#(
    parameter int ITERATIONS = ITERATIONS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iClear,
    input  logic             iInc,
    output logic [CNT_W-1:0] oCount,
    output logic             oTerminal
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign oTerminal = (count_q == CNT_W'(ITERATIONS - 1));
    assign oCount    = count_q;

    always_comb begin
        count_d = count_q;
        if (iClear) begin
            count_d = '0;
        end else if (iInc) begin
            count_d = oTerminal ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mult_control.sv
// Control FSM for the 32x32 shift-add multiplier datapath: request handshake,
// fixed-length add/shift sequence, then hold the product until it is taken.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | datapath tracks operand buses, product cleared, ready high
// CALC    | one add/shift per cycle, ITERATIONS cycles, no early exit
// DONE    | product held, result valid until the consumer accepts it
module mult_control
    import mult_control_pkg::*;
#(
    parameter int ITERATIONS = ITERATIONS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iReq_Valid,
    output logic             oReq_Ready,
    input  logic             iB_LSB,
    output logic             oB_Sel,
    output logic             oA_Sel,
    output logic             oProd_Sel,
    output logic             oShift_Enable,
    output logic             oAdd_Enable,
    output logic             oResult_Valid,
    input  logic             iResult_Ready,
    output logic             oBusy,
    output logic [CNT_W-1:0] oCycle_Count
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;
    logic             in_calc;

    assign in_calc = (state_q == ST_CALC);

    mult_iter_counter #(
        .ITERATIONS (ITERATIONS),
        .CNT_W      (CNT_W)
    ) u_iter_counter (
        .Clock     (Clock),
        .Reset     (Reset),
        .iClear    (!in_calc),
        .iInc      (in_calc),
        .oCount    (cnt),
        .oTerminal (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iReq_Valid)    state_d = ST_CALC;
            ST_CALC: if (cnt_term)      state_d = ST_DONE;
            ST_DONE: if (iResult_Ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode from registered state; only the add enable follows iB_LSB live.
    always_comb begin
        oReq_Ready    = 1'b0;
        oB_Sel        = SEL_FEEDBACK;
        oA_Sel        = SEL_FEEDBACK;
        oProd_Sel     = SEL_FEEDBACK;
        oShift_Enable = 1'b0;
        oAdd_Enable   = 1'b0;
        oResult_Valid = 1'b0;
        oBusy         = 1'b1;
        case (state_q)
            ST_IDLE: begin
                oReq_Ready = 1'b1;
                oB_Sel     = SEL_LOAD;
                oA_Sel     = SEL_LOAD;
                oProd_Sel  = SEL_LOAD;
                oBusy      = 1'b0;
            end
            ST_CALC: begin
                oShift_Enable = 1'b1;
                oAdd_Enable   = iB_LSB;
            end
            ST_DONE: begin
                oResult_Valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign oCycle_Count = in_calc ? cnt : '0;

endmodule

// File: tb/tb_mult_control.sv
// Directed bench for mult_control: a behavioural shift-add datapath closes the
// loop so each multiply is checked against a hand-computed product.
module tb_mult_control;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iReq_Valid;
    logic       oReq_Ready;
    logic       iB_LSB;
    logic       oB_Sel;
    logic       oA_Sel;
    logic       oProd_Sel;
    logic       oShift_Enable;
    logic       oAdd_Enable;
    logic       oResult_Valid;
    logic       iResult_Ready;
    logic       oBusy;
    logic [5:0] oCycle_Count;

    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic [63:0] a_q    = '0;
    logic [31:0] b_q    = '0;
    logic [63:0] prod_q = '0;

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    mult_control dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iReq_Valid    (iReq_Valid),
        .oReq_Ready    (oReq_Ready),
        .iB_LSB        (iB_LSB),
        .oB_Sel        (oB_Sel),
        .oA_Sel        (oA_Sel),
        .oProd_Sel     (oProd_Sel),
        .oShift_Enable (oShift_Enable),
        .oAdd_Enable   (oAdd_Enable),
        .oResult_Valid (oResult_Valid),
        .iResult_Ready (iResult_Ready),
        .oBusy         (oBusy),
        .oCycle_Count  (oCycle_Count)
    );

    // Datapath model: the add uses A before this edge's shift.
    assign iB_LSB = b_q[0];
    always @(posedge Clock) begin
        if (oA_Sel) a_q <= {32'b0, data_a};
        else if (oShift_Enable) a_q <= a_q << 1;
        if (oB_Sel) b_q <= data_b;
        else if (oShift_Enable) b_q <= b_q >> 1;
        if (oProd_Sel) prod_q <= '0;
        else if (oAdd_Enable) prod_q <= prod_q + a_q;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " req_ready"}, 64'(oReq_Ready), 64'd1);
        check({tag, " b_sel"}, 64'(oB_Sel), 64'd1);
        check({tag, " a_sel"}, 64'(oA_Sel), 64'd1);
        check({tag, " prod_sel"}, 64'(oProd_Sel), 64'd1);
        check({tag, " shift_en"}, 64'(oShift_Enable), 64'd0);
        check({tag, " add_en"}, 64'(oAdd_Enable), 64'd0);
        check({tag, " res_valid"}, 64'(oResult_Valid), 64'd0);
        check({tag, " busy"}, 64'(oBusy), 64'd0);
        check({tag, " cyc_cnt"}, 64'(oCycle_Count), 64'd0);
    endtask

    // Present operands while idle; returns in the first CALC cycle.
    task automatic start_req(input logic [31:0] a, input logic [31:0] b);
        data_a     = a;
        data_b     = b;
        iReq_Valid = 1'b1;
        check("req_ready before handshake", 64'(oReq_Ready), 64'd1);
        tick();
        iReq_Valid = 1'b0;
    endtask

    // Check n CALC cycles; add enable must follow successive bits of B.
    task automatic run_calc(input logic [31:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            check("calc add_en", 64'(oAdd_Enable), 64'(b[k]));
            check("calc cyc_cnt", 64'(oCycle_Count), 64'(k));
            check("calc shift_en", 64'(oShift_Enable), 64'd1);
            check("calc res_valid", 64'(oResult_Valid), 64'd0);
            check("calc req_ready", 64'(oReq_Ready), 64'd0);
            tick();
        end
    endtask

    // Stay in DONE for hold cycles with iResult_Ready low; product must not move.
    task automatic hold_done(input logic [63:0] exp, input int hold);
        for (int i = 0; i < hold; i++) begin
            check("done res_valid", 64'(oResult_Valid), 64'd1);
            check("done req_ready", 64'(oReq_Ready), 64'd0);
            check("done add_en", 64'(oAdd_Enable), 64'd0);
            check("done shift_en", 64'(oShift_Enable), 64'd0);
            check("done cyc_cnt", 64'(oCycle_Count), 64'd0);
            check("done product", prod_q, exp);
            tick();
        end
    endtask

    task automatic accept_result();
        iResult_Ready = 1'b1;
        tick();
        iResult_Ready = 1'b0;
        check("after accept req_ready", 64'(oReq_Ready), 64'd1);
        check("after accept res_valid", 64'(oResult_Valid), 64'd0);
    endtask

    initial begin
        Reset         = 1'b1;
        iReq_Valid    = 1'b0;
        iResult_Ready = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        check_idle("post reset");
        tick();
        tick();
        check_idle("idle no request");

        // 3 x 5: add enable 1,0,1,0,...; valid exactly 33 cycles after handshake
        start_req(32'd3, 32'd5);
        run_calc(32'd5, 32);
        hold_done(64'd15, 10);
        accept_result();
        tick();

        // all ones: add every cycle
        start_req(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_calc(32'hFFFF_FFFF, 32);
        hold_done(64'hFFFF_FFFE_0000_0001, 1);

        // both ready and request high while in DONE: request refused there
        data_a        = 32'd7;
        data_b        = 32'd6;
        iReq_Valid    = 1'b1;
        iResult_Ready = 1'b1;
        check("b2b done req_ready", 64'(oReq_Ready), 64'd0);
        check("b2b done res_valid", 64'(oResult_Valid), 64'd1);
        tick();
        check("b2b idle req_ready", 64'(oReq_Ready), 64'd1);
        check("b2b idle busy", 64'(oBusy), 64'd0);
        check("b2b idle res_valid", 64'(oResult_Valid), 64'd0);
        tick();
        iReq_Valid = 1'b0;
        check("b2b accepted busy", 64'(oBusy), 64'd1);
        run_calc(32'd6, 32);
        check("b2b res_valid", 64'(oResult_Valid), 64'd1);
        check("b2b product", prod_q, 64'd42);
        tick();
        iResult_Ready = 1'b0;
        check("b2b released req_ready", 64'(oReq_Ready), 64'd1);
        tick();

        // reset during iteration 12
        start_req(32'd100, 32'd3);
        run_calc(32'd3, 12);
        check("pre reset cyc_cnt", 64'(oCycle_Count), 64'd12);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_idle("mid calc reset");
        for (int i = 0; i < 40; i++) begin
            check("no valid after reset", 64'(oResult_Valid), 64'd0);
            tick();
        end
        start_req(32'd2, 32'd9);
        run_calc(32'd9, 32);
        hold_done(64'd18, 2);
        accept_result();
        tick();

        // B = 0: full length, never adds
        start_req(32'd12345, 32'd0);
        run_calc(32'd0, 32);
        hold_done(64'd0, 2);
        accept_result();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
